maxpool1_ram_writer: RTL and testbench

Write side of the MaxPool1 result RAM. It accepts the ConV1 output stream, one signed int8 per beat, and performs 2x2 stride-2 max pooling. Each pooled value is written into the result BRAM at a linear address. When the whole frame is written it raises `end_ConV1`, after which the readback port (`ram_en_rtb`/`ram_addr_rtb`/`ram_data_rtb`) may drain the RAM. The block sits between the ConV1 engine and the result BRAM port A.

---
 rtl/maxpool1_ram_writer_if.sv | 26 ++
 rtl/maxpool1_ram_writer.sv | 171 +++++++++++++++++
 tb/tb_maxpool1_ram_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool1_ram_writer_if.sv
// Stream-in / RAM-write bundle for the MaxPool1 result writer.
// The master side feeds ConV1 pixels and watches the RAM write port;
// the slave side is the pooling writer itself.
interface maxpool1_ram_writer_if #(
  parameter int DW = 8,
  parameter int AW = 16
) ();
  logic          start_ConV1;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          end_ConV1;

  modport master (
    output start_ConV1, in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_din, end_ConV1
  );

  modport slave (
    input  start_ConV1, in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_din, end_ConV1
  );
endinterface

// File: rtl/maxpool1_ram_writer.sv
// 2x2 stride-2 signed max pooling of the ConV1 output stream, written
// linearly into the MaxPool1 result RAM. Input order is channel-major
// raster; a half-row line buffer holds the horizontal maxima of even rows
// so every odd-row/odd-column beat produces exactly one RAM write.
module maxpool1_ram_writer #(
  parameter int IN_W = 48,
  parameter int IN_H = 48,
  parameter int CH   = 8,
  parameter int DW   = 8,
  parameter int AW   = 16
) (
  input logic                 sys_clk,
  input logic                 rst_n,
  maxpool1_ram_writer_if.slave bus
);
  localparam int XW  = $clog2(IN_W);
  localparam int RW  = $clog2(IN_H);
  localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int LBN = IN_W / 2;

  localparam logic [XW-1:0] X_LAST     = XW'(IN_W - 1);
  localparam logic [RW-1:0] R_LAST     = RW'(IN_H - 1);
  localparam logic [CW-1:0] C_LAST     = CW'(CH - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(IN_W / 2);
  localparam logic [AW-1:0] CH_STRIDE  = AW'((IN_H / 2) * (IN_W / 2));

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic signed [DW-1:0] smax(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_t                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [RW-1:0]          r_q, r_d;
  logic [CW-1:0]          c_q, c_d;
  logic                   last_q, last_d;
  logic                   in_ready_q, in_ready_d;
  logic                   ram_we_q, ram_we_d;
  logic [AW-1:0]          ram_addr_q, ram_addr_d;
  logic signed [DW-1:0]   ram_din_q, ram_din_d;
  logic                   end_q, end_d;
  logic signed [DW-1:0]   hreg_q, hreg_d;
  logic signed [DW-1:0]   lb_q [LBN];

  logic                   accept;
  logic                   lb_we;
  logic [XW-2:0]          lb_idx;
  logic signed [DW-1:0]   lb_wdata;
  logic signed [DW-1:0]   pix;
  logic signed [DW-1:0]   h;

  // Next-state, counter and pooling decisions; last_q marks the cycle
  // after the final beat so nothing more is taken before DONE.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    r_d        = r_q;
    c_d        = c_q;
    last_d     = last_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    end_d      = end_q;
    hreg_d     = hreg_q;
    lb_we      = 1'b0;
    pix        = bus.in_data;
    h          = smax(hreg_q, pix);
    lb_idx     = x_q[XW-1:1];
    lb_wdata   = h;
    accept     = bus.in_valid && in_ready_q && !last_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_ConV1) begin
          state_d = S_RUN;
          x_d     = '0;
          r_d     = '0;
          c_d     = '0;
          last_d  = 1'b0;
          end_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (last_q) begin
          state_d = S_DONE;
          last_d  = 1'b0;
          end_d   = 1'b1;
        end else if (accept) begin
          if (!x_q[0]) begin
            hreg_d = pix;
          end else if (!r_q[0]) begin
            lb_we = 1'b1;
          end else begin
            ram_we_d   = 1'b1;
            ram_din_d  = smax(lb_q[lb_idx], h);
            ram_addr_d = AW'(c_q) * CH_STRIDE + AW'(r_q >> 1) * ROW_STRIDE + AW'(lb_idx);
          end

          if (x_q == X_LAST) begin
            x_d = '0;
            if (r_q == R_LAST) begin
              r_d = '0;
              if (c_q == C_LAST) begin
                last_d = 1'b1;
              end else begin
                c_d = c_q + 1'b1;
              end
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RUN);
  end

  // Control state and registered outputs, cleared by synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      r_q        <= r_d;
      c_q        <= c_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      end_q      <= end_d;
    end
  end

  // Pooling storage; always written before it is read, so no reset.
  always_ff @(posedge sys_clk) begin
    hreg_q <= hreg_d;
    if (lb_we) begin
      lb_q[lb_idx] <= lb_wdata;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.end_ConV1 = end_q;

endmodule

// File: tb/tb_maxpool1_ram_writer.sv
// Bench for maxpool1_ram_writer: a 4x4x1 instance for exact timing and
// handshake checks and a default-size instance for a full frame.
module tb_maxpool1_ram_writer;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int SW = 4, SH = 4, SC = 1;
  localparam int LW = 48, LH = 48, LC = 8;
  localparam int SN = SW * SH * SC;
  localparam int LN = LW * LH * LC;
  localparam int LP = LN / 4;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maxpool1_ram_writer_if #(.DW(DW), .AW(AW)) bs ();
  maxpool1_ram_writer_if #(.DW(DW), .AW(AW)) bl ();

  maxpool1_ram_writer #(.IN_W(SW), .IN_H(SH), .CH(SC), .DW(DW), .AW(AW)) dut_s (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bs.slave)
  );

  maxpool1_ram_writer #(.IN_W(LW), .IN_H(LH), .CH(LC), .DW(DW), .AW(AW)) dut_l (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bl.slave)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;
  bit  run_s   = 1'b0;
  bit  pend_s  = 1'b0;
  bit  pend_l  = 1'b0;
  int  k_s     = 0;
  int  k_l     = 0;
  int  wl_cnt  = 0;
  wr_t exp_s[$];
  wr_t exp_l[$];
  int  mdl_l [LP];
  int  ram_l [LP];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference pooling: max over every 2x2 block, in raster write order.
  function automatic void build_exp(input int w, input int h, input int ch,
                                    input int fr[], input bit big);
    wr_t e;
    int  m;
    int  v;
    for (int c = 0; c < ch; c++)
      for (int pr = 0; pr < h / 2; pr++)
        for (int px = 0; px < w / 2; px++) begin
          m = -1000;
          for (int dr = 0; dr < 2; dr++)
            for (int dx = 0; dx < 2; dx++) begin
              v = fr[c * h * w + (2 * pr + dr) * w + 2 * px + dx];
              if (v > m) m = v;
            end
          e.addr = c * (h / 2) * (w / 2) + pr * (w / 2) + px;
          e.data = m;
          if (big) begin
            exp_l.push_back(e);
            mdl_l[e.addr] = m;
          end else begin
            exp_s.push_back(e);
          end
        end
  endfunction

  // Small instance: write timing from the accepted-beat index, write contents.
  always @(negedge clk) begin : mon_s
    wr_t e;
    if (mon_en) begin
      check("s_we_timing", bs.ram_we, pend_s);
      if (bs.ram_we) begin
        if (exp_s.size() == 0) check("s_extra_write", 1, 0);
        else begin
          e = exp_s.pop_front();
          check("s_addr", bs.ram_addr, e.addr);
          check("s_data", $signed(bs.ram_din), e.data);
        end
      end
      check("s_end_with_we", bs.ram_we && bs.end_ConV1, 0);
      if (run_s) check("s_ready_run", bs.in_ready, 1);
      pend_s = 1'b0;
      if (rst_n && bs.in_valid && bs.in_ready) begin
        pend_s = ((k_s % SW) % 2 == 1) && (((k_s / SW) % SH) % 2 == 1);
        k_s++;
      end
    end
  end

  // Large instance: same rules, plus a behavioural RAM image.
  always @(negedge clk) begin : mon_l
    wr_t e;
    if (mon_en) begin
      check("l_we_timing", bl.ram_we, pend_l);
      if (bl.ram_we) begin
        wl_cnt++;
        ram_l[bl.ram_addr % LP] = $signed(bl.ram_din);
        if (exp_l.size() == 0) check("l_extra_write", 1, 0);
        else begin
          e = exp_l.pop_front();
          check("l_addr", bl.ram_addr, e.addr);
          check("l_data", $signed(bl.ram_din), e.data);
        end
      end
      pend_l = 1'b0;
      if (rst_n && bl.in_valid && bl.in_ready) begin
        pend_l = ((k_l % LW) % 2 == 1) && (((k_l / LW) % LH) % 2 == 1);
        k_l++;
      end
    end
  end

  // mode 0: ramp, 1: signed corner pattern, 2: random; gap = % idle cycles
  task automatic frame_s(input int mode, input int gap);
    int f[];
    f = new[SN];
    for (int i = 0; i < SN; i++) begin
      case (mode)
        0:       f[i] = i;
        1:       f[i] = (i == 0) ? -2 : (i == 10) ? -1 : -128;
        default: f[i] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
    build_exp(SW, SH, SC, f, 1'b0);
    k_s = 0;
    bs.start_ConV1 = 1'b1;
    @(posedge clk); #1;
    bs.start_ConV1 = 1'b0;
    check("s_start_ready", bs.in_ready, 1);
    check("s_start_end", bs.end_ConV1, 0);
    run_s = 1'b1;
    for (int i = 0; i < SN; i++) begin
      while (int'($urandom_range(0, 99)) < gap) begin
        bs.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bs.in_valid = 1'b1;
      bs.in_data  = 8'(f[i]);
      @(posedge clk); #1;
    end
    bs.in_valid = 1'b0;
    run_s = 1'b0;
    check("s_last_we", bs.ram_we, 1);
    check("s_last_addr", bs.ram_addr, SN / 4 - 1);
    check("s_end_low", bs.end_ConV1, 0);
    @(posedge clk); #1;
    check("s_end_rise", bs.end_ConV1, 1);
    check("s_we_after", bs.ram_we, 0);
    check("s_writes_left", exp_s.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("s_end_hold", bs.end_ConV1, 1);
    check("s_ready_done", bs.in_ready, 0);
  endtask

  // Random frame on the large instance; stops after nbeats beats.
  task automatic frame_l(input int nbeats);
    int f[];
    f = new[LN];
    for (int i = 0; i < LN; i++) f[i] = int'($urandom_range(0, 255)) - 128;
    build_exp(LW, LH, LC, f, 1'b1);
    k_l    = 0;
    wl_cnt = 0;
    bl.start_ConV1 = 1'b1;
    @(posedge clk); #1;
    bl.start_ConV1 = 1'b0;
    check("l_start_ready", bl.in_ready, 1);
    bl.in_valid = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      bl.in_data = 8'(f[i]);
      @(posedge clk); #1;
    end
    bl.in_valid = 1'b0;
  endtask

  initial begin : main
    int t;
    rst_n = 1'b0;
    bs.start_ConV1 = 1'b1; bs.in_valid = 1'b1; bs.in_data = '0;
    bl.start_ConV1 = 1'b1; bl.in_valid = 1'b1; bl.in_data = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      mon_en = 1'b1;
      check("rst_s_ready", bs.in_ready, 0);
      check("rst_s_we", bs.ram_we, 0);
      check("rst_s_end", bs.end_ConV1, 0);
      check("rst_l_ready", bl.in_ready, 0);
      check("rst_l_we", bl.ram_we, 0);
      check("rst_l_addr", bl.ram_addr, 0);
    end
    rst_n = 1'b1;
    bs.start_ConV1 = 1'b0; bs.in_valid = 1'b0;
    bl.start_ConV1 = 1'b0; bl.in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_s_ready", bs.in_ready, 0);

    frame_s(0, 0);
    frame_s(1, 0);
    frame_s(0, 50);
    frame_s(2, 50);

    // abandon a large frame after 1000 beats with a one-cycle reset
    frame_l(1000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_l.delete();
    check("abort_l_end", bl.end_ConV1, 0);
    check("abort_l_ready", bl.in_ready, 0);
    check("abort_s_end", bs.end_ConV1, 0);
    frame_s(0, 0);
    check("abort_l_end_after", bl.end_ConV1, 0);
    frame_s(0, 0);

    // full default-size frame
    for (int a = 0; a < LP; a++) ram_l[a] = 9999;
    frame_l(LN);
    t = 0;
    while (!bl.end_ConV1 && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    check("l_end_latency", t, 1);
    check("l_write_count", wl_cnt, LP);
    check("l_writes_left", exp_l.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    check("l_end_hold", bl.end_ConV1, 1);
    for (int a = 0; a < 24; a++) check("l_readback", ram_l[a], mdl_l[a]);
    check("l_ram_last", ram_l[LP - 1], mdl_l[LP - 1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
